sram_block_reader: RTL and testbench

//  Streaming read-out stage downstream of the 512x32 TDP block-SRAM wrapper (port B).
//  On a start pulse it reads a contiguous (wrapping) range of words, one per cycle.
//  It absorbs the SRAM's 1-cycle read latency with a 2-entry skid FIFO and presents a

---
 rtl/sram_block_reader_pkg.sv | 21 ++
 rtl/sram_block_reader_fifo2_skid.sv | 84 ++++++++
 rtl/sram_block_reader.sv | 140 ++++++++++++++
 tb/tb_sram_block_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_block_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_block_reader_pkg
//  Purpose  : Shared definitions for the SRAM block reader: SRAM geometry and
//             the transfer-sequencer state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package sram_block_reader_pkg;

    localparam int SRAM_ABITS = 9;
    localparam int SRAM_DBITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sram_block_reader_fifo2_skid.sv
`default_nettype none
// ============================================================================
//  Module   : sram_block_reader_fifo2_skid
//  Purpose  : 2-entry synchronous skid FIFO with registered outputs. The head
//             entry drives dout_o directly, so output data is stable while the
//             consumer stalls.
//  Ports    : clk_i/rst_i  clock, synchronous active-high reset (empties FIFO)
//             push_i/din_i write strobe and data
//             pop_i        remove head entry (ignored when empty)
//             count_o      occupancy 0..2
//             dout_o       head entry
//  Revision : 1.0  initial release
// ============================================================================
module sram_block_reader_fifo2_skid #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic [1:0]       count_q, count_d;
    logic             pop_eff;
    logic             push_eff;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        count_d  = count_q;
        // A pop on an empty FIFO has nothing to remove; a push into a full
        // FIFO is only accepted when it is paired with a pop.
        pop_eff  = pop_i & (count_q != 2'd0);
        push_eff = push_i & ((count_q != 2'd2) | pop_eff);

        case ({push_eff, pop_eff})
            2'b10: begin
                if (count_q == 2'd0) begin
                    mem0_d = din_i;
                end else begin
                    mem1_d = din_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                mem0_d  = mem1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word goes behind any survivor.
                if (count_q == 2'd2) begin
                    mem0_d = mem1_q;
                    mem1_d = din_i;
                end else begin
                    mem0_d = din_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign dout_o  = mem0_q;

endmodule
`default_nettype wire

// File: rtl/sram_block_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sram_block_reader
//  Purpose  : On a start pulse, reads a contiguous (wrapping) range of SRAM
//             words one per cycle through port B and presents them as a
//             valid/ready stream with a last flag. A 2-entry skid FIFO absorbs
//             the SRAM's 1-cycle read latency.
//  Ports    : clk_i, rst_i             clock, synchronous active-high reset
//             start_i, base_i, len_i   transfer request (len 0 = empty)
//             busy_o, done_o           transfer status / completion pulse
//             ram_en_o, ram_we_o,
//             ram_addr_o, ram_dat_i    SRAM port B
//             m_valid_o, m_ready_i,
//             m_data_o, m_last_o       output stream
//  Revision : 1.0  initial release
// ============================================================================
module sram_block_reader
    import sram_block_reader_pkg::*;
#(
    parameter int ABITS = SRAM_ABITS,
    parameter int DBITS = SRAM_DBITS,
    parameter int DELAY = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [ABITS-1:0] base_i,
    input  logic [ABITS:0]   len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ram_en_o,
    output logic [3:0]       ram_we_o,
    output logic [ABITS-1:0] ram_addr_o,
    input  logic [DBITS-1:0] ram_dat_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [DBITS-1:0] m_data_o,
    output logic             m_last_o
);

    // DELAY only shapes simulation timing of a behavioural flavour; it has no
    // meaning in this zero-delay implementation.
    logic w_unused_delay;
    assign w_unused_delay = ^DELAY;

    state_e           state_q, state_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [ABITS:0]   rem_q, rem_d;
    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;

    logic [1:0]       fifo_count;
    logic [DBITS:0]   fifo_dout;
    logic             pop;
    logic [2:0]       occupancy;

    assign m_valid_o = (fifo_count != 2'd0);
    assign m_data_o  = fifo_dout[DBITS-1:0];
    assign m_last_o  = m_valid_o & fifo_dout[DBITS];
    assign pop       = m_valid_o & m_ready_i;

    // Words that will sit in the FIFO next cycle without a new read; a new
    // read is only issued when there is guaranteed room for its data.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

    assign ram_en_o   = (state_q == ST_READ) && (rem_q != '0) && (occupancy < 3'd2);
    assign ram_we_o   = 4'h0;
    assign ram_addr_o = addr_q;
    assign busy_o     = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = ram_en_o;
        inflight_last_d = ram_en_o && (rem_q == (ABITS+1)'(1));

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d  = base_i;
                    rem_d   = len_i;
                    state_d = (len_i == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (ram_en_o) begin
                    addr_d = addr_q + ABITS'(1);   // wraps modulo 2^ABITS
                    rem_d  = rem_q - (ABITS+1)'(1);
                    if (rem_q == (ABITS+1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && m_last_o) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // SRAM data is pushed unconditionally the cycle after the read strobe.
    sram_block_reader_fifo2_skid #(
        .WIDTH (DBITS + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight_q),
        .din_i   ({inflight_last_q, ram_dat_i}),
        .pop_i   (pop),
        .count_o (fifo_count),
        .dout_o  (fifo_dout)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_block_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_block_reader
//  Purpose  : Self-checking bench for sram_block_reader with a behavioural
//             SRAM model (word[a] = 32'hA5000000 | a).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_block_reader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [8:0]  base_i = '0;
    logic [9:0]  len_i = '0;
    logic        busy_o, done_o, ram_en_o, m_valid_o, m_last_o;
    logic [3:0]  ram_we_o;
    logic [8:0]  ram_addr_o;
    logic [31:0] ram_dat_i = '0;
    logic        m_ready_i = 1'b0;
    logic [31:0] m_data_o;

    sram_block_reader dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .base_i     (base_i),
        .len_i      (len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_dat_i  (ram_dat_i),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_data_o   (m_data_o),
        .m_last_o   (m_last_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural SRAM port B: registered read, 1-cycle latency.
    always @(posedge clk_i) begin
        if (ram_en_o) ram_dat_i <= 32'hA500_0000 | {23'd0, ram_addr_o};
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state
    logic [31:0] q_data[$];
    bit          q_last[$];
    int          q_cyc[$];
    int          en_count, first_en_cyc, first_valid_cyc, done_cnt, done_cyc;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    bit          prev_last;

    task automatic clear_mon();
        q_data.delete(); q_last.delete(); q_cyc.delete();
        en_count = 0; first_en_cyc = -1; first_valid_cyc = -1;
        done_cnt = 0; done_cyc = -1;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (ram_en_o) begin
                en_count++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
                chk("ram_we_zero", {60'd0, ram_we_o}, 64'd0);
            end
            // Issued-but-unconsumed words may never exceed FIFO depth + one in flight.
            chk("fifo_no_overflow", 64'(en_count - q_data.size() <= 3), 64'd1);
            if (m_valid_o) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (prev_stall) begin
                    chk("stall_data_stable", {32'd0, m_data_o}, {32'd0, prev_data});
                    chk("stall_last_stable", {63'd0, m_last_o}, {63'd0, prev_last});
                end
                if (m_ready_i) begin
                    q_data.push_back(m_data_o);
                    q_last.push_back(m_last_o);
                    q_cyc.push_back(cyc);
                end
            end
            prev_stall = m_valid_o & ~m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_at_done", {63'd0, busy_o}, 64'd0);
            end
        end else begin
            prev_stall = 0;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        #1;
        chk({tag, "_busy"},  {63'd0, busy_o},    64'd0);
        chk({tag, "_done"},  {63'd0, done_o},    64'd0);
        chk({tag, "_ram_en"},{63'd0, ram_en_o},  64'd0);
        chk({tag, "_addr"},  {55'd0, ram_addr_o},64'd0);
        chk({tag, "_valid"}, {63'd0, m_valid_o}, 64'd0);
        chk({tag, "_last"},  {63'd0, m_last_o},  64'd0);
    endtask

    typedef struct {
        logic [8:0]  base;
        logic [9:0]  len;
        int          mode;    // 0: ready always high, 1: ready toggles 1010...
        bit          second;  // issue a stray start mid-transfer
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    task automatic run_xfer(input vec_t v);
        int  c0;
        bit  finished;
        int  n;
        logic [31:0] exp;
        clear_mon();
        start_i   = 1'b1;
        base_i    = v.base;
        len_i     = v.len;
        m_ready_i = 1'b1;
        c0        = cyc;
        finished  = 0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            step();
            start_i = 1'b0;
            if (v.second && k == 5) begin
                start_i = 1'b1;
                base_i  = 9'h080;
                len_i   = 10'd5;
            end
            if (v.mode == 1) m_ready_i = ~m_ready_i;
            if (done_cnt > 0) finished = 1;
        end
        if (!finished) chk("done_timeout", 64'd0, 64'd1);
        m_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) step();

        n = int'(v.len);
        chk("beat_count", 64'(q_data.size()), 64'(n));
        chk("read_count", 64'(en_count), 64'(n));
        chk("done_count", 64'(done_cnt), 64'd1);
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            exp = 32'hA500_0000 | 32'((int'(v.base) + i) % 512);
            chk("beat_data", {32'd0, q_data[i]}, {32'd0, exp});
            chk("beat_last", {63'd0, q_last[i]}, 64'(i == n - 1));
        end
        if (n > 0 && q_data.size() == n) begin
            chk("first_word", {32'd0, q_data[0]},   {32'd0, v.exp_first});
            chk("last_word",  {32'd0, q_data[n-1]}, {32'd0, v.exp_last});
            chk("done_after_last", 64'(done_cyc), 64'(q_cyc[n-1] + 1));
            if (v.mode == 0) begin
                chk("first_en_latency",    64'(first_en_cyc),    64'(c0 + 1));
                chk("first_valid_latency", 64'(first_valid_cyc), 64'(c0 + 3));
                chk("last_beat_cycle",     64'(q_cyc[n-1]),      64'(c0 + 2 + n));
            end
        end
        if (n == 0) begin
            chk("zero_len_done_cycle", 64'(done_cyc), 64'(c0 + 1));
            chk("zero_len_no_valid",   64'(first_valid_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{9'h000, 10'd512, 0, 1'b0, 32'hA500_0000, 32'hA500_01FF};
        vecs[1] = '{9'h1FE, 10'd4,   0, 1'b0, 32'hA500_01FE, 32'hA500_0001};
        vecs[2] = '{9'h010, 10'd8,   1, 1'b0, 32'hA500_0010, 32'hA500_0017};
        vecs[3] = '{9'h055, 10'd0,   0, 1'b0, 32'h0,         32'h0};
        vecs[4] = '{9'h100, 10'd10,  0, 1'b1, 32'hA500_0100, 32'hA500_0109};
        vecs[5] = '{9'h1FF, 10'd1,   1, 1'b0, 32'hA500_01FF, 32'hA500_01FF};
        vecs[6] = '{9'h1FF, 10'd512, 1, 1'b0, 32'hA500_01FF, 32'hA500_01FE};
        clear_mon();

        rst_i = 1'b1;
        step(); step();
        chk_reset_outputs("reset");
        rst_i = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i]);
        end

        // Start in the DONE cycle of an empty transfer must be dropped.
        clear_mon();
        start_i = 1'b1; base_i = 9'h005; len_i = 10'd0;
        step();
        chk("done_cycle_state", {63'd0, done_o}, 64'd1);
        len_i = 10'd2;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("start_in_done_no_reads", 64'(en_count), 64'd0);
        chk("start_in_done_one_done", 64'(done_cnt), 64'd1);
        chk("start_in_done_not_busy", {63'd0, busy_o}, 64'd0);

        // Reset after three beats of a 16-word transfer aborts without done.
        clear_mon();
        start_i = 1'b1; base_i = 9'h020; len_i = 10'd16; m_ready_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 50 && q_data.size() < 3; k++) step();
        chk("abort_beats_seen", 64'(q_data.size()), 64'd3);
        rst_i = 1'b1;
        @(posedge clk_i);
        chk_reset_outputs("abort");
        step();
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_no_valid_after", {63'd0, m_valid_o}, 64'd0);
        run_xfer('{9'h040, 10'd3, 0, 1'b0, 32'hA500_0040, 32'hA500_0042});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
